// File: rtl/cpu_pkg.sv
// Shared encodings for the multicycle MIPS controller: FSM states, opcode/funct
// fields, ALU operation codes and trap causes.
package cpu_pkg;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_RTYPE_EX, S_ALU_WB, S_IMM_EX, S_IMM_WB, S_MEM_ADDR, S_MEM_RD,
    S_MEM_WB, S_MEM_WR, S_BRANCH, S_JR_PC, S_JAL_LINK, S_JUMP, S_MD_WAIT, S_TRAP
  } state_t;

  typedef enum logic [1:0] {
    TC_NONE    = 2'b00,
    TC_ILLEGAL = 2'b01,
    TC_TIMEOUT = 2'b10
  } trap_cause_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] F_SLL  = 6'h00;
  localparam logic [5:0] F_SRL  = 6'h02;
  localparam logic [5:0] F_SRA  = 6'h03;
  localparam logic [5:0] F_JR   = 6'h08;
  localparam logic [5:0] F_MULT = 6'h18;
  localparam logic [5:0] F_DIV  = 6'h1A;
  localparam logic [5:0] F_ADD  = 6'h20;
  localparam logic [5:0] F_ADDU = 6'h21;
  localparam logic [5:0] F_SUB  = 6'h22;
  localparam logic [5:0] F_SUBU = 6'h23;
  localparam logic [5:0] F_AND  = 6'h24;
  localparam logic [5:0] F_OR   = 6'h25;
  localparam logic [5:0] F_XOR  = 6'h26;
  localparam logic [5:0] F_NOR  = 6'h27;
  localparam logic [5:0] F_SLT  = 6'h2A;

  localparam logic [3:0] ALU_ADD = 4'h0;
  localparam logic [3:0] ALU_SUB = 4'h1;
  localparam logic [3:0] ALU_AND = 4'h2;
  localparam logic [3:0] ALU_OR  = 4'h3;
  localparam logic [3:0] ALU_XOR = 4'h4;
  localparam logic [3:0] ALU_NOR = 4'h5;
  localparam logic [3:0] ALU_SLT = 4'h6;
  localparam logic [3:0] ALU_SLL = 4'h7;
  localparam logic [3:0] ALU_SRL = 4'h8;
  localparam logic [3:0] ALU_SRA = 4'h9;

  function automatic logic is_shift(logic [5:0] f);
    return (f == F_SLL) || (f == F_SRL) || (f == F_SRA);
  endfunction

  // ALU-class functs only; JR and MULT/DIV are sequenced separately.
  function automatic logic funct_legal(logic [5:0] f);
    case (f)
      F_SLL, F_SRL, F_SRA, F_ADD, F_ADDU, F_SUB, F_SUBU,
      F_AND, F_OR, F_XOR, F_NOR, F_SLT: return 1'b1;
      default:                          return 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] funct_alu(logic [5:0] f);
    case (f)
      F_SUB, F_SUBU: return ALU_SUB;
      F_AND:         return ALU_AND;
      F_OR:          return ALU_OR;
      F_XOR:         return ALU_XOR;
      F_NOR:         return ALU_NOR;
      F_SLT:         return ALU_SLT;
      F_SLL:         return ALU_SLL;
      F_SRL:         return ALU_SRL;
      F_SRA:         return ALU_SRA;
      default:       return ALU_ADD;
    endcase
  endfunction

  function automatic logic [3:0] imm_alu(logic [5:0] op);
    case (op)
      OP_SLTI: return ALU_SLT;
      OP_ANDI: return ALU_AND;
      OP_ORI:  return ALU_OR;
      OP_XORI: return ALU_XOR;
      default: return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_ctrl_hs_mem_watchdog.sv
// Bus-cycle watchdog: counts stalled cycles of the current memory access and
// flags a timeout on the last permitted stall. MEM_TIMEOUT=0 disables it.
module mem_watchdog #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clk_en,
  input  logic active,
  input  logic mem_ready,
  output logic timeout
);

  localparam int CNT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MEM_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;

  // Completion clears the count so back-to-back accesses (MEM_WR -> FETCH) each
  // get a full budget; outside memory states the counter idles at zero.
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (!active) begin
      wait_cnt_d = '0;
    end else if (clk_en) begin
      if (mem_ready)                  wait_cnt_d = '0;
      else if (wait_cnt_q != CNT_MAX) wait_cnt_d = wait_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) wait_cnt_q <= '0;
    else      wait_cnt_q <= wait_cnt_d;
  end

  assign timeout = (MEM_TIMEOUT != 0) && active && !mem_ready && (wait_cnt_q == CNT_LAST);

endmodule

// File: rtl/multicycle_ctrl_hs.sv
// Multicycle MIPS control FSM with handshaked memory, bus watchdog, optional
// MULT/DIV sequencing and a sticky trap for illegal instructions / hung buses.
module multicycle_ctrl_hs
  import cpu_pkg::*;
#(
  parameter int ALU_CTRL_W  = 4,
  parameter int MEM_TIMEOUT = 16,
  parameter bit MD_EN       = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clk_en,
  input  logic [5:0]            opcode,
  input  logic [5:0]            funct,
  input  logic                  mem_ready,
  input  logic                  md_done,
  output logic                  mem_req,
  output logic                  IorD,
  output logic                  IRWrite,
  output logic                  PCWrite,
  output logic                  RegWrite,
  output logic                  MemWrite,
  output logic                  MemtoReg,
  output logic                  Branch,
  output logic                  BranchType,
  output logic [1:0]            ALUSrcA,
  output logic [2:0]            ALUSrcB,
  output logic [1:0]            PCSrc,
  output logic [1:0]            RegDst,
  output logic [ALU_CTRL_W-1:0] ALUControl,
  output logic                  md_start,
  output logic                  trap,
  output logic [1:0]            trap_cause
);

  state_t      state_q, state_d, nxt;
  trap_cause_t trap_cause_q, trap_cause_d, cause_nxt;
  logic [3:0]  alu;
  logic        mem_active, timeout;

  assign mem_active = (state_q == S_FETCH) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR);

  mem_watchdog #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_wdog (
    .clk       (clk),
    .rst       (rst),
    .clk_en    (clk_en),
    .active    (mem_active),
    .mem_ready (mem_ready),
    .timeout   (timeout)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= S_FETCH;
      trap_cause_q <= TC_NONE;
    end else begin
      state_q      <= state_d;
      trap_cause_q <= trap_cause_d;
    end
  end

  always_comb begin
    nxt        = state_q;
    cause_nxt  = trap_cause_q;
    mem_req    = 1'b0;
    IorD       = 1'b0;
    IRWrite    = 1'b0;
    PCWrite    = 1'b0;
    RegWrite   = 1'b0;
    MemWrite   = 1'b0;
    MemtoReg   = 1'b0;
    Branch     = 1'b0;
    BranchType = 1'b0;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 3'b000;
    PCSrc      = 2'b00;
    RegDst     = 2'b00;
    alu        = ALU_ADD;
    md_start   = 1'b0;

    case (state_q)
      S_FETCH: begin
        mem_req = 1'b1;
        ALUSrcB = 3'b001;
        IRWrite = mem_ready;
        PCWrite = mem_ready;
        if (mem_ready)    nxt = S_DECODE;
        else if (timeout) begin nxt = S_TRAP; cause_nxt = TC_TIMEOUT; end
      end
      S_DECODE: begin
        ALUSrcB = 3'b011;
        case (opcode)
          OP_RTYPE:                                nxt = S_RTYPE_EX;
          OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI: nxt = S_IMM_EX;
          OP_LW, OP_SW:                            nxt = S_MEM_ADDR;
          OP_BEQ, OP_BNE:                          nxt = S_BRANCH;
          OP_JAL:                                  nxt = S_JAL_LINK;
          OP_J:                                    nxt = S_JUMP;
          default: begin nxt = S_TRAP; cause_nxt = TC_ILLEGAL; end
        endcase
      end
      S_RTYPE_EX: begin
        alu = funct_alu(funct);
        if (is_shift(funct)) begin
          ALUSrcA = 2'b10;
          ALUSrcB = 3'b100;
        end else begin
          ALUSrcA = 2'b01;
        end
        if (funct == F_JR) begin
          nxt = S_JR_PC;
        end else if ((funct == F_MULT) || (funct == F_DIV)) begin
          if (MD_EN) begin
            // Qualified by clk_en so a frozen pipeline cannot restart the unit.
            md_start = clk_en;
            nxt      = S_MD_WAIT;
          end else begin
            nxt = S_TRAP; cause_nxt = TC_ILLEGAL;
          end
        end else if (funct_legal(funct)) begin
          nxt = S_ALU_WB;
        end else begin
          nxt = S_TRAP; cause_nxt = TC_ILLEGAL;
        end
      end
      S_ALU_WB: begin
        RegDst   = 2'b01;
        RegWrite = 1'b1;
        nxt      = S_FETCH;
      end
      S_IMM_EX: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 3'b010;
        alu     = imm_alu(opcode);
        nxt     = S_IMM_WB;
      end
      S_IMM_WB: begin
        RegWrite = 1'b1;
        nxt      = S_FETCH;
      end
      S_MEM_ADDR: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 3'b010;
        nxt     = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        mem_req = 1'b1;
        IorD    = 1'b1;
        if (mem_ready)    nxt = S_MEM_WB;
        else if (timeout) begin nxt = S_TRAP; cause_nxt = TC_TIMEOUT; end
      end
      S_MEM_WB: begin
        MemtoReg = 1'b1;
        RegWrite = 1'b1;
        nxt      = S_FETCH;
      end
      S_MEM_WR: begin
        mem_req  = 1'b1;
        IorD     = 1'b1;
        MemWrite = mem_ready;
        if (mem_ready)    nxt = S_FETCH;
        else if (timeout) begin nxt = S_TRAP; cause_nxt = TC_TIMEOUT; end
      end
      S_BRANCH: begin
        ALUSrcA    = 2'b01;
        alu        = ALU_SUB;
        PCSrc      = 2'b01;
        Branch     = 1'b1;
        BranchType = (opcode == OP_BEQ);
        nxt        = S_FETCH;
      end
      S_JR_PC: begin
        PCSrc   = 2'b11;
        PCWrite = 1'b1;
        nxt     = S_FETCH;
      end
      S_JAL_LINK: begin
        ALUSrcB  = 3'b001;
        RegDst   = 2'b10;
        RegWrite = 1'b1;
        nxt      = S_JUMP;
      end
      S_JUMP: begin
        PCSrc   = 2'b10;
        PCWrite = 1'b1;
        nxt     = S_FETCH;
      end
      S_MD_WAIT: begin
        if (md_done) nxt = S_ALU_WB;
      end
      S_TRAP: begin
        nxt = S_TRAP;
      end
      default: begin
        nxt = S_TRAP; cause_nxt = TC_ILLEGAL;
      end
    endcase

    state_d      = clk_en ? nxt : state_q;
    trap_cause_d = clk_en ? cause_nxt : trap_cause_q;
  end

  assign ALUControl = ALU_CTRL_W'(alu);
  assign trap       = (state_q == S_TRAP);
  assign trap_cause = trap_cause_q;

endmodule

// File: tb/tb_multicycle_ctrl_hs.sv
// Bench for multicycle_ctrl_hs: per-cycle vectors expand through a small output
// model into a scoreboard compared against two differently-parameterised DUTs.
module tb_multicycle_ctrl_hs;
  import cpu_pkg::*;

  typedef enum logic [4:0] {
    P_FETCH, P_DECODE, P_RTYPE, P_ALUWB, P_IMMEX, P_IMMWB, P_MADDR, P_MRD,
    P_MWB, P_MWR, P_BR, P_JR, P_JAL, P_JUMP, P_MDW, P_TRAP
  } phase_t;

  typedef struct {
    logic       rst_n;
    logic       en;
    logic [5:0] op;
    logic [5:0] fn;
    logic       rdy;
    logic       mdd;
    phase_t     ph;
    logic [1:0] cause;
    logic       which;
  } vec_t;

  typedef struct packed {
    logic       mem_req, iord, irw, pcw, regw, memw, m2r, br, brt;
    logic [1:0] srca;
    logic [2:0] srcb;
    logic [1:0] pcsrc, regdst;
    logic [3:0] alu;
    logic       md_start, trap;
    logic [1:0] cause;
  } out_t;

  typedef struct {
    out_t exp;
    logic which;
    int   idx;
  } sb_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, clk_en, mem_ready, md_done;
  logic [5:0] opcode, funct;

  logic       a_mem_req, a_iord, a_irw, a_pcw, a_regw, a_memw, a_m2r, a_br, a_brt, a_md, a_trap;
  logic [1:0] a_srca, a_pcsrc, a_regdst, a_cause;
  logic [2:0] a_srcb;
  logic [3:0] a_alu;
  logic       b_mem_req, b_iord, b_irw, b_pcw, b_regw, b_memw, b_m2r, b_br, b_brt, b_md, b_trap;
  logic [1:0] b_srca, b_pcsrc, b_regdst, b_cause;
  logic [2:0] b_srcb;
  logic [3:0] b_alu;
  out_t       oa, ob;

  // u_a: long watchdog with MULT/DIV; u_b: short watchdog, MULT/DIV illegal.
  multicycle_ctrl_hs #(.ALU_CTRL_W(4), .MEM_TIMEOUT(16), .MD_EN(1'b1)) u_a (
    .clk(clk), .rst(rst), .clk_en(clk_en), .opcode(opcode), .funct(funct),
    .mem_ready(mem_ready), .md_done(md_done), .mem_req(a_mem_req), .IorD(a_iord),
    .IRWrite(a_irw), .PCWrite(a_pcw), .RegWrite(a_regw), .MemWrite(a_memw),
    .MemtoReg(a_m2r), .Branch(a_br), .BranchType(a_brt), .ALUSrcA(a_srca),
    .ALUSrcB(a_srcb), .PCSrc(a_pcsrc), .RegDst(a_regdst), .ALUControl(a_alu),
    .md_start(a_md), .trap(a_trap), .trap_cause(a_cause));

  multicycle_ctrl_hs #(.ALU_CTRL_W(4), .MEM_TIMEOUT(4), .MD_EN(1'b0)) u_b (
    .clk(clk), .rst(rst), .clk_en(clk_en), .opcode(opcode), .funct(funct),
    .mem_ready(mem_ready), .md_done(md_done), .mem_req(b_mem_req), .IorD(b_iord),
    .IRWrite(b_irw), .PCWrite(b_pcw), .RegWrite(b_regw), .MemWrite(b_memw),
    .MemtoReg(b_m2r), .Branch(b_br), .BranchType(b_brt), .ALUSrcA(b_srca),
    .ALUSrcB(b_srcb), .PCSrc(b_pcsrc), .RegDst(b_regdst), .ALUControl(b_alu),
    .md_start(b_md), .trap(b_trap), .trap_cause(b_cause));

  assign oa = {a_mem_req, a_iord, a_irw, a_pcw, a_regw, a_memw, a_m2r, a_br, a_brt,
               a_srca, a_srcb, a_pcsrc, a_regdst, a_alu, a_md, a_trap, a_cause};
  assign ob = {b_mem_req, b_iord, b_irw, b_pcw, b_regw, b_memw, b_m2r, b_br, b_brt,
               b_srca, b_srcb, b_pcsrc, b_regdst, b_alu, b_md, b_trap, b_cause};

  vec_t tbl[$];
  sb_t  sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   vec_no = 0;

  function automatic out_t model(vec_t v);
    out_t o;
    o     = '0;
    o.alu = ALU_ADD;
    case (v.ph)
      P_FETCH:  begin o.mem_req = 1'b1; o.srcb = 3'd1; o.irw = v.rdy; o.pcw = v.rdy; end
      P_DECODE: o.srcb = 3'd3;
      P_RTYPE: begin
        if (v.fn == F_SLL) begin o.srca = 2'd2; o.srcb = 3'd4; o.alu = ALU_SLL; end
        else begin
          o.srca = 2'd1;
          if (v.fn == F_SUB) o.alu = ALU_SUB;
        end
        o.md_start = (v.fn == F_MULT || v.fn == F_DIV) && !v.which;
      end
      P_ALUWB:  begin o.regdst = 2'd1; o.regw = 1'b1; end
      P_IMMEX:  begin o.srca = 2'd1; o.srcb = 3'd2; if (v.op == OP_ORI) o.alu = ALU_OR; end
      P_IMMWB:  o.regw = 1'b1;
      P_MADDR:  begin o.srca = 2'd1; o.srcb = 3'd2; end
      P_MRD:    begin o.mem_req = 1'b1; o.iord = 1'b1; end
      P_MWB:    begin o.m2r = 1'b1; o.regw = 1'b1; end
      P_MWR:    begin o.mem_req = 1'b1; o.iord = 1'b1; o.memw = v.rdy; end
      P_BR: begin
        o.srca = 2'd1; o.alu = ALU_SUB; o.pcsrc = 2'd1; o.br = 1'b1; o.brt = (v.op == OP_BEQ);
      end
      P_JR:     begin o.pcsrc = 2'd3; o.pcw = 1'b1; end
      P_JAL:    begin o.regdst = 2'd2; o.regw = 1'b1; o.srcb = 3'd1; end
      P_JUMP:   begin o.pcsrc = 2'd2; o.pcw = 1'b1; end
      P_MDW:    ;
      P_TRAP:   begin o.trap = 1'b1; o.cause = v.cause; end
      default:  ;
    endcase
    return o;
  endfunction

  task automatic add(input phase_t ph, input logic [5:0] op, input logic [5:0] fn = 6'h00,
                     input logic rdy = 1'b1, input logic en = 1'b1, input logic mdd = 1'b0,
                     input logic [1:0] cause = 2'd0, input logic which = 1'b0);
    tbl.push_back('{rst_n:1'b1, en:en, op:op, fn:fn, rdy:rdy, mdd:mdd, ph:ph, cause:cause, which:which});
  endtask

  task automatic rst_row();
    tbl.push_back('{rst_n:1'b0, en:1'b1, op:6'h00, fn:6'h00, rdy:1'b0, mdd:1'b0,
                    ph:P_FETCH, cause:2'd0, which:1'b0});
  endtask

  task automatic apply_tbl();
    sb_t se;
    for (int i = 0; i < tbl.size(); i++) begin
      @(posedge clk); #1;
      rst       = tbl[i].rst_n;
      clk_en    = tbl[i].en;
      opcode    = tbl[i].op;
      funct     = tbl[i].fn;
      mem_ready = tbl[i].rdy;
      md_done   = tbl[i].mdd;
      if (tbl[i].rst_n) begin
        se.exp   = model(tbl[i]);
        se.which = tbl[i].which;
        se.idx   = vec_no;
        sb.push_back(se);
      end
      vec_no++;
    end
    tbl.delete();
  endtask

  sb_t  mon_e;
  out_t mon_got;
  always @(negedge clk) begin
    if (sb.size() != 0) begin
      mon_e   = sb.pop_front();
      mon_got = mon_e.which ? ob : oa;
      n_cmp++;
      if (mon_got !== mon_e.exp) begin
        n_bad++;
        $display("FAIL vec%0d dut%0d: got %h expected %h", mon_e.idx, mon_e.which, mon_got, mon_e.exp);
      end
    end
  end

  initial begin
    rst = 1'b0; clk_en = 1'b1; opcode = '0; funct = '0; mem_ready = 1'b0; md_done = 1'b0;

    // Main table: reset state and one pass through each instruction class.
    rst_row();
    add(P_FETCH, OP_RTYPE, F_ADD, 1'b0);
    add(P_FETCH, OP_RTYPE, F_ADD); add(P_DECODE, OP_RTYPE, F_ADD);
    add(P_RTYPE, OP_RTYPE, F_ADD); add(P_ALUWB, OP_RTYPE, F_ADD);
    add(P_FETCH, OP_RTYPE, F_SUB); add(P_DECODE, OP_RTYPE, F_SUB);
    add(P_RTYPE, OP_RTYPE, F_SUB); add(P_ALUWB, OP_RTYPE, F_SUB);
    add(P_FETCH, OP_RTYPE, F_SLL); add(P_DECODE, OP_RTYPE, F_SLL);
    add(P_RTYPE, OP_RTYPE, F_SLL); add(P_ALUWB, OP_RTYPE, F_SLL);
    add(P_FETCH, OP_ADDI); add(P_DECODE, OP_ADDI); add(P_IMMEX, OP_ADDI); add(P_IMMWB, OP_ADDI);
    add(P_FETCH, OP_ORI);  add(P_DECODE, OP_ORI);  add(P_IMMEX, OP_ORI);  add(P_IMMWB, OP_ORI);
    add(P_FETCH, OP_BEQ); add(P_DECODE, OP_BEQ); add(P_BR, OP_BEQ);
    add(P_FETCH, OP_BNE); add(P_DECODE, OP_BNE); add(P_BR, OP_BNE);
    add(P_FETCH, OP_JAL); add(P_DECODE, OP_JAL); add(P_JAL, OP_JAL); add(P_JUMP, OP_JAL);
    add(P_FETCH, OP_J);   add(P_DECODE, OP_J);   add(P_JUMP, OP_J);
    add(P_FETCH, OP_RTYPE, F_JR); add(P_DECODE, OP_RTYPE, F_JR);
    add(P_RTYPE, OP_RTYPE, F_JR); add(P_JR, OP_RTYPE, F_JR);
    // clk_en low freezes state while strobes still follow mem_ready
    add(P_FETCH, OP_J, 6'h00, 1'b1, 1'b0); add(P_FETCH, OP_J);
    add(P_DECODE, OP_J, 6'h00, 1'b1, 1'b0); add(P_DECODE, OP_J); add(P_JUMP, OP_J);
    // illegal opcode traps, stays trapped, reset recovers
    add(P_FETCH, 6'h3F); add(P_DECODE, 6'h3F);
    add(P_TRAP, 6'h3F, 6'h00, 1'b1, 1'b1, 1'b0, 2'd1); add(P_TRAP, 6'h3F, 6'h00, 1'b1, 1'b1, 1'b0, 2'd1);
    rst_row();
    add(P_FETCH, OP_RTYPE, 6'h3F, 1'b0);
    // illegal funct
    add(P_FETCH, OP_RTYPE, 6'h3F); add(P_DECODE, OP_RTYPE, 6'h3F);
    add(P_RTYPE, OP_RTYPE, 6'h3F); add(P_TRAP, OP_RTYPE, 6'h3F, 1'b1, 1'b1, 1'b0, 2'd1);
    apply_tbl();

    // LW: fetch ready after 3 waits, load ready after 2 waits
    rst_row();
    for (int i = 0; i < 3; i++) add(P_FETCH, OP_LW, 6'h00, 1'b0);
    add(P_FETCH, OP_LW); add(P_DECODE, OP_LW); add(P_MADDR, OP_LW);
    for (int i = 0; i < 2; i++) add(P_MRD, OP_LW, 6'h00, 1'b0);
    add(P_MRD, OP_LW); add(P_MWB, OP_LW); add(P_FETCH, OP_LW, 6'h00, 1'b0);
    apply_tbl();

    // SW: ready only on the 5th MEM_WR cycle
    rst_row();
    add(P_FETCH, OP_SW); add(P_DECODE, OP_SW); add(P_MADDR, OP_SW);
    for (int i = 0; i < 4; i++) add(P_MWR, OP_SW, 6'h00, 1'b0);
    add(P_MWR, OP_SW); add(P_FETCH, OP_SW, 6'h00, 1'b0);
    apply_tbl();

    // Watchdog (timeout 4): stuck load traps, ready on the 4th cycle does not
    rst_row();
    add(P_FETCH, OP_LW, 6'h00, 1'b1, 1'b1, 1'b0, 2'd0, 1'b1);
    add(P_DECODE, OP_LW, 6'h00, 1'b1, 1'b1, 1'b0, 2'd0, 1'b1);
    add(P_MADDR, OP_LW, 6'h00, 1'b1, 1'b1, 1'b0, 2'd0, 1'b1);
    for (int i = 0; i < 4; i++) add(P_MRD, OP_LW, 6'h00, 1'b0, 1'b1, 1'b0, 2'd0, 1'b1);
    add(P_TRAP, OP_LW, 6'h00, 1'b1, 1'b1, 1'b0, 2'd2, 1'b1);
    rst_row();
    add(P_FETCH, OP_LW, 6'h00, 1'b1, 1'b1, 1'b0, 2'd0, 1'b1);
    add(P_DECODE, OP_LW, 6'h00, 1'b1, 1'b1, 1'b0, 2'd0, 1'b1);
    add(P_MADDR, OP_LW, 6'h00, 1'b1, 1'b1, 1'b0, 2'd0, 1'b1);
    for (int i = 0; i < 3; i++) add(P_MRD, OP_LW, 6'h00, 1'b0, 1'b1, 1'b0, 2'd0, 1'b1);
    add(P_MRD, OP_LW, 6'h00, 1'b1, 1'b1, 1'b0, 2'd0, 1'b1);
    add(P_MWB, OP_LW, 6'h00, 1'b1, 1'b1, 1'b0, 2'd0, 1'b1);
    add(P_FETCH, OP_LW, 6'h00, 1'b0, 1'b1, 1'b0, 2'd0, 1'b1);
    rst_row();
    for (int i = 0; i < 4; i++) add(P_FETCH, OP_LW, 6'h00, 1'b0, 1'b1, 1'b0, 2'd0, 1'b1);
    add(P_TRAP, OP_LW, 6'h00, 1'b0, 1'b1, 1'b0, 2'd2, 1'b1);
    apply_tbl();

    // MULT with md_done after 7 wait cycles; MD_EN=0 instance traps instead
    rst_row();
    add(P_FETCH, OP_RTYPE, F_MULT); add(P_DECODE, OP_RTYPE, F_MULT); add(P_RTYPE, OP_RTYPE, F_MULT);
    for (int i = 0; i < 6; i++) add(P_MDW, OP_RTYPE, F_MULT);
    add(P_MDW, OP_RTYPE, F_MULT, 1'b1, 1'b1, 1'b1);
    add(P_ALUWB, OP_RTYPE, F_MULT); add(P_FETCH, OP_RTYPE, F_MULT, 1'b0);
    rst_row();
    add(P_FETCH, OP_RTYPE, F_MULT, 1'b1, 1'b1, 1'b0, 2'd0, 1'b1);
    add(P_DECODE, OP_RTYPE, F_MULT, 1'b1, 1'b1, 1'b0, 2'd0, 1'b1);
    add(P_RTYPE, OP_RTYPE, F_MULT, 1'b1, 1'b1, 1'b0, 2'd0, 1'b1);
    add(P_TRAP, OP_RTYPE, F_MULT, 1'b1, 1'b1, 1'b0, 2'd1, 1'b1);
    apply_tbl();

    // Reset mid-store: no write strobe once back in FETCH
    rst_row();
    add(P_FETCH, OP_SW); add(P_DECODE, OP_SW); add(P_MADDR, OP_SW);
    add(P_MWR, OP_SW, 6'h00, 1'b0);
    rst_row();
    add(P_FETCH, OP_SW); add(P_DECODE, OP_SW);
    apply_tbl();

    @(negedge clk); #1;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
